ecc_scrub_ctrl: RTL and testbench

ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

---
 rtl/ecc_scrub_ctrl.sv | 115 +++++++++++
 tb/tb_ecc_scrub_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_scrub_ctrl.sv
// Background ECC scrubber: sweeps every memory word, runs it through an external
// SEC decoder, and writes corrected words back while yielding to host traffic.
module ecc_scrub_ctrl #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INTERVAL = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              host_req_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  input  logic [7:0]        mem_rchk_i,
  output logic [31:0]       dec_data_o,
  output logic [7:0]        dec_chk_o,
  output logic              dec_en_o,
  input  logic [31:0]       dec_corr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       corr_cnt_o
);

  localparam int unsigned CNT_W = (INTERVAL > 0) ? $clog2(INTERVAL + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INTERVAL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_RESP,
    S_CHECK,
    S_WB,
    S_NEXT
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr;

  // Request drops in the same cycle the host claims the memory, so it cannot
  // wait for a clock edge; everything else is decoded from registered state.
  assign mem_req_o  = ((state == S_READ) || (state == S_WB)) && !host_req_i;
  assign mem_we_o   = (state == S_WB);
  assign mem_addr_o = addr;
  assign dec_en_o   = (state == S_CHECK);
  assign busy_o     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      addr        <= '0;
      mem_wdata_o <= '0;
      dec_data_o  <= '0;
      dec_chk_o   <= '0;
      done_o      <= 1'b0;
      corr_cnt_o  <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            addr  <= '0;
            cnt   <= CNT_LOAD;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_READ;
          else           cnt   <= cnt - CNT_W'(1);
        end
        S_READ: begin
          if (mem_req_o && mem_gnt_i) state <= S_RESP;
        end
        S_RESP: begin
          if (mem_rvalid_i) begin
            dec_data_o <= mem_rdata_i;
            dec_chk_o  <= mem_rchk_i;
            state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Check-bit-only errors decode back to the stored data and are skipped.
          if (dec_corr_i != dec_data_o) begin
            mem_wdata_o <= dec_corr_i;
            if (corr_cnt_o != '1) corr_cnt_o <= corr_cnt_o + 16'd1;
            state <= S_WB;
          end else begin
            state <= S_NEXT;
          end
        end
        S_WB: begin
          if (mem_req_o && mem_gnt_i) state <= S_NEXT;
        end
        S_NEXT: begin
          if (addr == '1) begin
            done_o <= 1'b1;
            state  <= S_IDLE;
          end else begin
            addr  <= addr + ADDR_W'(1);
            cnt   <= CNT_LOAD;
            state <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl: a 4-word memory with one-cycle grant/read
// latency and a toy single-bit-correcting decoder, plus a second INTERVAL=3 instance.
module tb_ecc_scrub_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        host = 1'b0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [7:0]  rchk = '0;
  logic        req, we, dec_en, busy, done;
  logic [1:0]  addr;
  logic [31:0] wdata, dec_data, dec_corr;
  logic [7:0]  dec_chk;
  logic [15:0] corr;

  logic        start3 = 1'b0;
  logic        req3, we3, dec_en3, busy3, done3;
  logic [1:0]  addr3;
  logic [31:0] wdata3, dec_data3;
  logic [7:0]  dec_chk3;
  logic [15:0] corr3;

  int unsigned checks = 0;
  int unsigned passed = 0;

  logic [31:0] gold [4] = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h0F0F_00FF, 32'hCAFE_F00D};
  logic [31:0] mem  [4];
  logic [7:0]  chk  [4];

  logic        req_prev = 1'b0;
  logic        rd_pend = 1'b0;
  logic [1:0]  rd_a = '0;
  logic [1:0]  rd_log [$];
  logic [1:0]  wa_log [$];
  logic [31:0] wd_log [$];
  int unsigned done_cnt = 0;
  int unsigned host_viol = 0;

  always #5 clk = ~clk;

  ecc_scrub_ctrl #(.ADDR_W(2), .INTERVAL(0)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .host_req_i(host),
    .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr), .mem_wdata_o(wdata),
    .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata), .mem_rchk_i(rchk),
    .dec_data_o(dec_data), .dec_chk_o(dec_chk), .dec_en_o(dec_en), .dec_corr_i(dec_corr),
    .busy_o(busy), .done_o(done), .corr_cnt_o(corr)
  );

  ecc_scrub_ctrl #(.ADDR_W(2), .INTERVAL(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start_i(start3), .host_req_i(1'b0),
    .mem_req_o(req3), .mem_we_o(we3), .mem_addr_o(addr3), .mem_wdata_o(wdata3),
    .mem_gnt_i(1'b1), .mem_rvalid_i(1'b1), .mem_rdata_i(32'hA5A5_0000), .mem_rchk_i(8'h00),
    .dec_data_o(dec_data3), .dec_chk_o(dec_chk3), .dec_en_o(dec_en3), .dec_corr_i(dec_data3),
    .busy_o(busy3), .done_o(done3), .corr_cnt_o(corr3)
  );

  // Toy decoder: check bits [1:0] name the word; a single-bit data difference is corrected.
  logic [31:0] diff;
  always_comb begin
    diff     = dec_data ^ gold[dec_chk[1:0]];
    dec_corr = dec_data;
    if (diff != '0 && (diff & (diff - 32'd1)) == '0) dec_corr = gold[dec_chk[1:0]];
  end

  // Memory responder: grant after a request has been visible for one cycle, data one cycle later.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (req && host) host_viol++;
    if (!rst_n) begin
      gnt = 1'b0; rvalid = 1'b0; req_prev = 1'b0; rd_pend = 1'b0;
    end else begin
      rvalid = rd_pend;
      if (rd_pend) begin rdata = mem[rd_a]; rchk = chk[rd_a]; end
      rd_pend = 1'b0;
      gnt = req && req_prev;
      if (gnt) begin
        if (we) begin wa_log.push_back(addr); wd_log.push_back(wdata); end
        else begin rd_log.push_back(addr); rd_pend = 1'b1; rd_a = addr; end
      end
      req_prev = req && !gnt;
    end
  end

  task automatic load_mem();
    for (int i = 0; i < 4; i++) begin
      mem[i] = gold[i];
      chk[i] = 8'(i);
    end
  endtask

  task automatic start_pulse();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (req !== 1'b0 || we !== 1'b0) $display("FAIL reset_req: got req=%b we=%b want 0", req, we); else passed++;
    checks++; if (corr !== 16'h0) $display("FAIL reset_corr: got %h want 0000", corr); else passed++;
    checks++; if (done !== 1'b0 || dec_en !== 1'b0) $display("FAIL reset_flags: got done=%b dec_en=%b want 0", done, dec_en); else passed++;
    checks++; if (addr !== 2'd0 || wdata !== 32'h0 || dec_data !== 32'h0) $display("FAIL reset_regs: got addr=%h wdata=%h dec=%h want 0", addr, wdata, dec_data); else passed++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0 || req !== 1'b0) $display("FAIL reset_stay_idle: got busy=%b req=%b want 0", busy, req); else passed++;
  endtask

  task automatic test_clean_sweep();
    int unsigned rb, wb, db;
    bit ok;
    load_mem();
    rb = rd_log.size(); wb = wa_log.size(); db = done_cnt;
    start_pulse();
    wait_done(ok);
    checks++; if (!ok) $display("FAIL clean_timeout: no done_o within budget"); else passed++;
    checks++; if (rd_log.size() - rb !== 4) $display("FAIL clean_reads: got %0d want 4", rd_log.size() - rb); else passed++;
    for (int i = 0; i < 4 && rb + i < rd_log.size(); i++) begin
      checks++; if (rd_log[rb+i] !== 2'(i)) $display("FAIL clean_addr%0d: got %0d want %0d", i, rd_log[rb+i], i); else passed++;
    end
    checks++; if (wa_log.size() - wb !== 0) $display("FAIL clean_writes: got %0d want 0", wa_log.size() - wb); else passed++;
    checks++; if (corr !== 16'h0) $display("FAIL clean_corr: got %h want 0000", corr); else passed++;
    checks++; if (done_cnt - db !== 1) $display("FAIL clean_done_pulses: got %0d want 1", done_cnt - db); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL clean_busy_after: got %b want 0", busy); else passed++;
  endtask

  task automatic test_single_error();
    int unsigned wb;
    bit ok;
    load_mem();
    mem[2] = 32'h0F0F_00DF;  // bit 5 flipped
    wb = wa_log.size();
    start_pulse();
    wait_done(ok);
    checks++; if (!ok) $display("FAIL err_timeout: no done_o within budget"); else passed++;
    checks++; if (wa_log.size() - wb !== 1) $display("FAIL err_writes: got %0d want 1", wa_log.size() - wb); else passed++;
    if (wa_log.size() > wb) begin
      checks++; if (wa_log[wb] !== 2'd2) $display("FAIL err_waddr: got %0d want 2", wa_log[wb]); else passed++;
      checks++; if (wd_log[wb] !== 32'h0F0F_00FF) $display("FAIL err_wdata: got %h want 0f0f00ff", wd_log[wb]); else passed++;
    end
    checks++; if (corr !== 16'd1) $display("FAIL err_corr: got %h want 0001", corr); else passed++;
  endtask

  task automatic test_chk_flip();
    int unsigned wb;
    bit ok;
    load_mem();
    chk[1] = 8'h81;
    wb = wa_log.size();
    start_pulse();
    wait_done(ok);
    checks++; if (!ok) $display("FAIL chkflip_timeout: no done_o within budget"); else passed++;
    checks++; if (wa_log.size() - wb !== 0) $display("FAIL chkflip_writes: got %0d want 0", wa_log.size() - wb); else passed++;
    checks++; if (corr !== 16'd1) $display("FAIL chkflip_corr: got %h want 0001", corr); else passed++;
  endtask

  task automatic test_accumulate();
    int unsigned wb;
    bit ok;
    load_mem();
    mem[3] = 32'h4AFE_F00D;  // bit 31 flipped
    wb = wa_log.size();
    start_pulse();
    wait_done(ok);
    checks++; if (!ok) $display("FAIL accum_timeout: no done_o within budget"); else passed++;
    checks++; if (wa_log.size() - wb !== 1 || wa_log[wa_log.size()-1] !== 2'd3) $display("FAIL accum_write: got %0d writes want 1 at addr 3", wa_log.size() - wb); else passed++;
    checks++; if (corr !== 16'd2) $display("FAIL accum_corr: got %h want 0002", corr); else passed++;
  endtask

  task automatic test_host_yield();
    int unsigned rb, vb, lowcnt;
    bit ok, found;
    load_mem();
    rb = rd_log.size(); vb = host_viol; found = 1'b0; lowcnt = 0;
    start_pulse();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (req && addr == 2'd1 && !we) begin found = 1'b1; break; end
    end
    checks++; if (!found) $display("FAIL host_reach_read: read of addr 1 never seen"); else passed++;
    host = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req !== 1'b0) lowcnt++;
    end
    checks++; if (lowcnt !== 0) $display("FAIL host_req_low: got %0d cycles with req want 0", lowcnt); else passed++;
    @(posedge clk); #1;
    host = 1'b0;
    #1;
    checks++; if (req !== 1'b1 || addr !== 2'd1 || we !== 1'b0) $display("FAIL host_resume: got req=%b addr=%0d we=%b want 1,1,0", req, addr, we); else passed++;
    wait_done(ok);
    checks++; if (!ok) $display("FAIL host_timeout: no done_o within budget"); else passed++;
    checks++; if (rd_log.size() - rb !== 4) $display("FAIL host_reads: got %0d want 4", rd_log.size() - rb); else passed++;
    if (rd_log.size() - rb >= 2) begin
      checks++; if (rd_log[rb+1] !== 2'd1) $display("FAIL host_read_addr: got %0d want 1", rd_log[rb+1]); else passed++;
    end
    checks++; if (host_viol - vb !== 0) $display("FAIL host_overlap: got %0d want 0", host_viol - vb); else passed++;
  endtask

  task automatic test_reset_in_wb();
    int unsigned wb, bad;
    bit found;
    load_mem();
    mem[1] = 32'hDEAD_BEEE;  // bit 0 flipped
    wb = wa_log.size(); found = 1'b0; bad = 0;
    start_pulse();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (req && we) begin found = 1'b1; break; end
    end
    checks++; if (!found) $display("FAIL rstwb_reach_wb: writeback never seen"); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (req !== 1'b0) $display("FAIL rstwb_req: got %b want 0", req); else passed++;
    checks++; if (corr !== 16'h0 || busy !== 1'b0) $display("FAIL rstwb_state: got corr=%h busy=%b want 0000,0", corr, busy); else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL rstwb_idle_after: got %0d active cycles want 0", bad); else passed++;
    checks++; if (wa_log.size() - wb !== 0) $display("FAIL rstwb_no_write: got %0d want 0", wa_log.size() - wb); else passed++;
  endtask

  task automatic test_saturation();
    int unsigned wb;
    bit ok;
    load_mem();
    mem[0] = 32'h1234_5679;
    mem[1] = 32'hDEAD_BEED;
    mem[2] = 32'h0F0F_00FB;
    mem[3] = 32'hCAFE_F005;
    @(negedge clk);
    force dut.corr_cnt_o = 16'hFFFD;
    @(negedge clk);
    release dut.corr_cnt_o;
    @(negedge clk);
    checks++; if (corr !== 16'hFFFD) $display("FAIL sat_preload: got %h want fffd", corr); else passed++;
    wb = wa_log.size();
    start_pulse();
    wait_done(ok);
    checks++; if (!ok) $display("FAIL sat_timeout: no done_o within budget"); else passed++;
    checks++; if (wa_log.size() - wb !== 4) $display("FAIL sat_writes: got %0d want 4", wa_log.size() - wb); else passed++;
    checks++; if (corr !== 16'hFFFF) $display("FAIL sat_corr: got %h want ffff", corr); else passed++;
  endtask

  task automatic test_interval();
    int unsigned req_t [$];
    logic [1:0]  req_a [$];
    int unsigned done_t, en_cnt, we_cnt, busy_after;
    done_t = 0; en_cnt = 0; we_cnt = 0; busy_after = 0;
    @(negedge clk); start3 = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start3 = (n == 10);
      if (req3) begin req_t.push_back(n); req_a.push_back(addr3); end
      if (dec_en3) en_cnt++;
      if (we3) we_cnt++;
      if (done3 && done_t == 0) done_t = n;
      if (n > 33 && busy3) busy_after++;
    end
    start3 = 1'b0;
    checks++; if (req_t.size() !== 4) $display("FAIL intv_reqs: got %0d want 4", req_t.size()); else passed++;
    for (int i = 0; i < 4 && i < req_t.size(); i++) begin
      checks++; if (req_t[i] !== 5 + 8 * i || req_a[i] !== 2'(i)) $display("FAIL intv_req%0d: got t=%0d a=%0d want t=%0d a=%0d", i, req_t[i], req_a[i], 5 + 8 * i, i); else passed++;
    end
    checks++; if (done_t !== 33) $display("FAIL intv_done: got cycle %0d want 33", done_t); else passed++;
    checks++; if (busy_after !== 0) $display("FAIL intv_restart: got %0d busy cycles want 0", busy_after); else passed++;
    checks++; if (en_cnt !== 4 || we_cnt !== 0) $display("FAIL intv_dec: got en=%0d we=%0d want 4,0", en_cnt, we_cnt); else passed++;
    checks++; if (corr3 !== 16'h0 || dec_chk3 !== 8'h0 || wdata3 !== 32'h0 || dec_data3 !== 32'hA5A5_0000) $display("FAIL intv_regs: got corr=%h chk=%h wdata=%h dec=%h", corr3, dec_chk3, wdata3, dec_data3); else passed++;
  endtask

  initial begin
    load_mem();
    test_reset();
    test_clean_sweep();
    test_single_error();
    test_chk_flip();
    test_accumulate();
    test_host_yield();
    test_interval();
    test_reset_in_wb();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
